// File: rtl/bcd_rtc_pkg.sv
// Shared BCD digit and time types, digit limits and the validation helpers
// used by the time-of-day counter.
package bcd_rtc_pkg;

  localparam logic [3:0] SEC_MSB_MAX      = 4'd5;
  localparam logic [3:0] DIGIT_MAX        = 4'd9;
  localparam logic [3:0] HR_MAX_MSB       = 4'd2;
  localparam logic [3:0] HR_MAX_LSB_AT_2  = 4'd3;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t msb;
    bcd_t lsb;
  } bcd_pair_t;

  typedef struct packed {
    bcd_pair_t hr;
    bcd_pair_t min;
    bcd_pair_t sec;
  } rtc_time_t;

  function automatic logic hr_valid(input bcd_pair_t h);
    if (h.msb < HR_MAX_MSB)
      return (h.lsb <= DIGIT_MAX);
    else
      return (h.msb == HR_MAX_MSB) && (h.lsb <= HR_MAX_LSB_AT_2);
  endfunction

  function automatic logic ms_valid(input bcd_pair_t p);
    return (p.msb <= SEC_MSB_MAX) && (p.lsb <= DIGIT_MAX);
  endfunction

endpackage

// File: rtl/bcd_rtc_alarm_digit.sv
// One modulo-(MAX+1) BCD digit; load beats the external wrap, which beats
// the increment. carry flags the digit rolling over on this increment.
module bcd_mod_digit
  import bcd_rtc_pkg::*;
#(
  parameter logic [3:0] MAX = 4'd9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       load,
  input  logic [3:0] ld_val,
  input  logic       wrap_now,
  output logic [3:0] q,
  output logic       carry
);

  assign carry = inc && (q == MAX);

  always_ff @(posedge clk) begin
    if (reset)
      q <= '0;
    else if (load)
      q <= ld_val;
    else if (wrap_now)
      q <= '0;
    else if (inc)
      q <= carry ? '0 : q + 4'd1;
  end

endmodule

// File: rtl/bcd_rtc_alarm.sv
// 24-hour BCD time-of-day counter with seconds prescaler, validated load,
// 12/24-hour display and a single daily alarm with ack and timeout.
module bcd_rtc_alarm
  import bcd_rtc_pkg::*;
#(
  parameter int TICK_DIV   = 1,
  parameter int ALARM_SECS = 10,
  parameter int CNT_W      = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] ld_hr_msb,
  input  logic [3:0] ld_hr_lsb,
  input  logic [3:0] ld_min_msb,
  input  logic [3:0] ld_min_lsb,
  input  logic [3:0] ld_sec_msb,
  input  logic [3:0] ld_sec_lsb,
  input  logic       al_set,
  input  logic [3:0] al_hr_msb,
  input  logic [3:0] al_hr_lsb,
  input  logic [3:0] al_min_msb,
  input  logic [3:0] al_min_lsb,
  input  logic       al_en,
  input  logic       al_ack,
  input  logic       mode_12h,
  output logic [3:0] hr_out_msb,
  output logic [3:0] hr_out_lsb,
  output logic [3:0] min_out_msb,
  output logic [3:0] min_out_lsb,
  output logic [3:0] sec_out_msb,
  output logic [3:0] sec_out_lsb,
  output logic       pm,
  output logic       sec_tick,
  output logic       load_err,
  output logic       alarm_ring
);

  localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [7:0]       RING_LOAD  = 8'(ALARM_SECS);

  rtc_time_t        ld_time;
  rtc_time_t        nxt;
  bcd_pair_t        al_in_hr;
  bcd_pair_t        al_in_min;
  bcd_pair_t        al_hr;
  bcd_pair_t        al_min;
  logic             al_valid;
  logic             time_ok;
  logic             al_ok;
  logic             load_ok;
  logic             tick;
  logic             adv;
  logic             hour_wrap;
  logic             trigger;
  logic [CNT_W-1:0] presc;
  logic [7:0]       ring_cnt;

  logic [3:0] sec_lsb, sec_msb, min_lsb, min_msb, hr_lsb, hr_msb;
  logic       c_sl, c_sm, c_ml, c_mm, c_hl;

  assign ld_time   = {ld_hr_msb, ld_hr_lsb, ld_min_msb, ld_min_lsb, ld_sec_msb, ld_sec_lsb};
  assign al_in_hr  = {al_hr_msb, al_hr_lsb};
  assign al_in_min = {al_min_msb, al_min_lsb};

  assign time_ok = hr_valid(ld_time.hr) && ms_valid(ld_time.min) && ms_valid(ld_time.sec);
  assign al_ok   = hr_valid(al_in_hr) && ms_valid(al_in_min);
  assign load_ok = load && time_ok;

  // A valid load swallows the tick of the same cycle.
  assign tick = (presc == PRESC_LAST);
  assign adv  = tick && !load_ok;

  assign hour_wrap = c_mm && (hr_msb == HR_MAX_MSB) && (hr_lsb == HR_MAX_LSB_AT_2);

  always_ff @(posedge clk) begin
    if (reset)
      presc <= '0;
    else if (load_ok || tick)
      presc <= '0;
    else
      presc <= presc + CNT_W'(1);
  end

  bcd_mod_digit #(.MAX(DIGIT_MAX)) u_sec_lsb (
    .clk(clk), .reset(reset), .inc(adv), .load(load_ok), .ld_val(ld_time.sec.lsb),
    .wrap_now(1'b0), .q(sec_lsb), .carry(c_sl)
  );

  bcd_mod_digit #(.MAX(SEC_MSB_MAX)) u_sec_msb (
    .clk(clk), .reset(reset), .inc(c_sl), .load(load_ok), .ld_val(ld_time.sec.msb),
    .wrap_now(1'b0), .q(sec_msb), .carry(c_sm)
  );

  bcd_mod_digit #(.MAX(DIGIT_MAX)) u_min_lsb (
    .clk(clk), .reset(reset), .inc(c_sm), .load(load_ok), .ld_val(ld_time.min.lsb),
    .wrap_now(1'b0), .q(min_lsb), .carry(c_ml)
  );

  bcd_mod_digit #(.MAX(SEC_MSB_MAX)) u_min_msb (
    .clk(clk), .reset(reset), .inc(c_ml), .load(load_ok), .ld_val(ld_time.min.msb),
    .wrap_now(1'b0), .q(min_msb), .carry(c_mm)
  );

  bcd_mod_digit #(.MAX(DIGIT_MAX)) u_hr_lsb (
    .clk(clk), .reset(reset), .inc(c_mm), .load(load_ok), .ld_val(ld_time.hr.lsb),
    .wrap_now(hour_wrap), .q(hr_lsb), .carry(c_hl)
  );

  // Hour tens never carries; it only steps 0->1->2 and is cleared at 23->00.
  always_ff @(posedge clk) begin
    if (reset)
      hr_msb <= '0;
    else if (load_ok)
      hr_msb <= ld_time.hr.msb;
    else if (hour_wrap)
      hr_msb <= '0;
    else if (c_hl)
      hr_msb <= hr_msb + 4'd1;
  end

  function automatic bcd_t nxt_dig(input bcd_t q, input logic inc, input logic carry);
    if (carry)
      return '0;
    else if (inc)
      return q + 4'd1;
    else
      return q;
  endfunction

  // Time as it will be after this edge, so the alarm can rise with it.
  always_comb begin
    nxt         = '0;
    nxt.sec.lsb = nxt_dig(sec_lsb, adv, c_sl);
    nxt.sec.msb = nxt_dig(sec_msb, c_sl, c_sm);
    nxt.min.lsb = nxt_dig(min_lsb, c_sm, c_ml);
    nxt.min.msb = nxt_dig(min_msb, c_ml, c_mm);
    nxt.hr.lsb  = nxt_dig(hr_lsb, c_mm, c_hl);
    nxt.hr.msb  = nxt_dig(hr_msb, c_hl, 1'b0);
    if (hour_wrap)
      nxt.hr = '0;
    if (load_ok)
      nxt = ld_time;
  end

  assign trigger = al_en && al_valid && (adv || load_ok) &&
                   (nxt.hr == al_hr) && (nxt.min == al_min) && (nxt.sec == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      al_hr    <= '0;
      al_min   <= '0;
      al_valid <= 1'b0;
    end else if (al_set && al_ok) begin
      al_hr    <= al_in_hr;
      al_min   <= al_in_min;
      al_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sec_tick <= 1'b0;
      load_err <= 1'b0;
    end else begin
      sec_tick <= adv;
      load_err <= (load && !time_ok) || (al_set && !al_ok);
    end
  end

  // Trigger outranks ack/disable; the countdown follows the displayed seconds.
  always_ff @(posedge clk) begin
    if (reset) begin
      alarm_ring <= 1'b0;
      ring_cnt   <= '0;
    end else if (trigger) begin
      alarm_ring <= 1'b1;
      ring_cnt   <= RING_LOAD;
    end else if (al_ack || !al_en) begin
      alarm_ring <= 1'b0;
      ring_cnt   <= '0;
    end else if (alarm_ring && adv) begin
      if (ring_cnt <= 8'd1) begin
        alarm_ring <= 1'b0;
        ring_cnt   <= '0;
      end else begin
        ring_cnt   <= ring_cnt - 8'd1;
      end
    end
  end

  always_comb begin
    hr_out_msb = hr_msb;
    hr_out_lsb = hr_lsb;
    if (mode_12h) begin
      if (hr_msb == 4'd0 && hr_lsb == 4'd0) begin
        hr_out_msb = 4'd1;
        hr_out_lsb = 4'd2;
      end else if (hr_msb == 4'd1 && hr_lsb >= 4'd3) begin
        hr_out_msb = 4'd0;
        hr_out_lsb = hr_lsb - 4'd2;
      end else if (hr_msb == 4'd2) begin
        if (hr_lsb <= 4'd1) begin
          hr_out_msb = 4'd0;
          hr_out_lsb = hr_lsb + 4'd8;
        end else begin
          hr_out_msb = 4'd1;
          hr_out_lsb = hr_lsb - 4'd2;
        end
      end
    end
  end

  assign pm          = (hr_msb == 4'd2) || (hr_msb == 4'd1 && hr_lsb >= 4'd2);
  assign min_out_msb = min_msb;
  assign min_out_lsb = min_lsb;
  assign sec_out_msb = sec_msb;
  assign sec_out_lsb = sec_lsb;

endmodule

// File: tb/tb_bcd_rtc_alarm.sv
// Directed bench: one instance ticking every cycle (alarm timeout 3 s) and
// one with a divide-by-4 prescaler, both driven from the same stimulus.
module tb_bcd_rtc_alarm;

  logic clk = 1'b0;
  logic reset, load, al_set, al_en, al_ack, mode_12h;
  logic [3:0] ld_hr_msb, ld_hr_lsb, ld_min_msb, ld_min_lsb, ld_sec_msb, ld_sec_lsb;
  logic [3:0] al_hr_msb, al_hr_lsb, al_min_msb, al_min_lsb;

  logic [3:0] a_hm, a_hl, a_mm, a_ml, a_sm, a_sl;
  logic       a_pm, a_tick, a_err, a_ring;
  logic [3:0] b_hm, b_hl, b_mm, b_ml, b_sm, b_sl;
  logic       b_pm, b_tick, b_err, b_ring;

  logic [23:0] ta, tb;
  assign ta = {a_hm, a_hl, a_mm, a_ml, a_sm, a_sl};
  assign tb = {b_hm, b_hl, b_mm, b_ml, b_sm, b_sl};

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bcd_rtc_alarm #(.TICK_DIV(1), .ALARM_SECS(3), .CNT_W(8)) u_fast (
    .clk(clk), .reset(reset), .load(load),
    .ld_hr_msb(ld_hr_msb), .ld_hr_lsb(ld_hr_lsb), .ld_min_msb(ld_min_msb),
    .ld_min_lsb(ld_min_lsb), .ld_sec_msb(ld_sec_msb), .ld_sec_lsb(ld_sec_lsb),
    .al_set(al_set), .al_hr_msb(al_hr_msb), .al_hr_lsb(al_hr_lsb),
    .al_min_msb(al_min_msb), .al_min_lsb(al_min_lsb),
    .al_en(al_en), .al_ack(al_ack), .mode_12h(mode_12h),
    .hr_out_msb(a_hm), .hr_out_lsb(a_hl), .min_out_msb(a_mm), .min_out_lsb(a_ml),
    .sec_out_msb(a_sm), .sec_out_lsb(a_sl),
    .pm(a_pm), .sec_tick(a_tick), .load_err(a_err), .alarm_ring(a_ring)
  );

  bcd_rtc_alarm #(.TICK_DIV(4), .ALARM_SECS(3), .CNT_W(8)) u_div4 (
    .clk(clk), .reset(reset), .load(load),
    .ld_hr_msb(ld_hr_msb), .ld_hr_lsb(ld_hr_lsb), .ld_min_msb(ld_min_msb),
    .ld_min_lsb(ld_min_lsb), .ld_sec_msb(ld_sec_msb), .ld_sec_lsb(ld_sec_lsb),
    .al_set(al_set), .al_hr_msb(al_hr_msb), .al_hr_lsb(al_hr_lsb),
    .al_min_msb(al_min_msb), .al_min_lsb(al_min_lsb),
    .al_en(al_en), .al_ack(al_ack), .mode_12h(mode_12h),
    .hr_out_msb(b_hm), .hr_out_lsb(b_hl), .min_out_msb(b_mm), .min_out_lsb(b_ml),
    .sec_out_msb(b_sm), .sec_out_lsb(b_sl),
    .pm(b_pm), .sec_tick(b_tick), .load_err(b_err), .alarm_ring(b_ring)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_ld(input logic [23:0] v);
    {ld_hr_msb, ld_hr_lsb, ld_min_msb, ld_min_lsb, ld_sec_msb, ld_sec_lsb} = v;
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; al_set = 1'b0; al_en = 1'b0; al_ack = 1'b0; mode_12h = 1'b0;
    set_ld(24'h000000);
    {al_hr_msb, al_hr_lsb, al_min_msb, al_min_lsb} = 16'h0000;
    step(); step();
    chk("rst_time", ta, 24'h000000);
    chk("rst_time_div4", tb, 24'h000000);
    chk("rst_ring", a_ring, 1'b0);
    chk("rst_err", a_err, 1'b0);
    chk("rst_tick", a_tick, 1'b0);
    chk("rst_pm", a_pm, 1'b0);
    chk("rst_div4_flags", {b_ring, b_err, b_pm}, 3'b000);

    // Divide-by-4 prescaler free-running from reset release.
    reset = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      step();
      chk($sformatf("div4_tick_c%0d", i), b_tick, (i % 4 == 0));
    end
    chk("div4_sec_12cyc", tb, 24'h000003);

    // Load two cycles after reset restarts the prescaler.
    reset = 1'b1; step(); reset = 1'b0;
    step(); step();
    set_ld(24'h123456); load = 1'b1; step(); load = 1'b0;
    chk("div4_load_time", tb, 24'h123456);
    chk("div4_load_notick", b_tick, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      step();
      chk($sformatf("div4_post_load_c%0d", i), b_tick, (i == 4));
    end
    chk("div4_post_load_time", tb, 24'h123457);

    // Midnight rollover, 24-hour display.
    set_ld(24'h235958); load = 1'b1; step(); load = 1'b0;
    chk("roll_load", ta, 24'h235958);
    chk("roll_load_tick", a_tick, 1'b0);
    chk("roll_load_pm", a_pm, 1'b1);
    step();
    chk("roll_59", ta, 24'h235959);
    chk("roll_59_tick", a_tick, 1'b1);
    chk("roll_59_pm", a_pm, 1'b1);
    step();
    chk("roll_00", ta, 24'h000000);
    chk("roll_00_tick", a_tick, 1'b1);
    chk("roll_00_pm", a_pm, 1'b0);

    // 12-hour display mapping.
    mode_12h = 1'b1; load = 1'b1;
    set_ld(24'h001500); step();
    chk("h12_0015", ta, 24'h121500);
    chk("h12_0015_pm", a_pm, 1'b0);
    set_ld(24'h130500); step();
    chk("h12_1305", ta, 24'h010500);
    chk("h12_1305_pm", a_pm, 1'b1);
    set_ld(24'h120000); step();
    chk("h12_1200", ta, 24'h120000);
    chk("h12_1200_pm", a_pm, 1'b1);
    set_ld(24'h220000); step();
    chk("h12_2200", ta, 24'h100000);
    chk("h12_2200_err", a_err, 1'b0);
    load = 1'b0; mode_12h = 1'b0; step();
    chk("h24_after_toggle", ta, 24'h220001);

    // Rejected loads leave the time running and pulse load_err once.
    set_ld(24'h240000); load = 1'b1; step();
    chk("bad_hr_time", ta, 24'h220002);
    chk("bad_hr_err", a_err, 1'b1);
    load = 1'b0; step();
    chk("bad_hr_err_clr", a_err, 1'b0);
    chk("bad_hr_time2", ta, 24'h220003);
    set_ld(24'h126000); load = 1'b1; step();
    chk("bad_min_time", ta, 24'h220004);
    chk("bad_min_err", a_err, 1'b1);
    load = 1'b0; step();
    chk("bad_min_err_clr", a_err, 1'b0);

    // Valid load with a rejected al_set in the same cycle.
    set_ld(24'h090000); load = 1'b1;
    {al_hr_msb, al_hr_lsb, al_min_msb, al_min_lsb} = 16'h2500; al_set = 1'b1;
    step();
    chk("ld_bad_al_time", ta, 24'h090000);
    chk("ld_bad_al_err", a_err, 1'b1);
    load = 1'b0; al_set = 1'b0; step();
    chk("ld_bad_al_err_clr", a_err, 1'b0);

    // Alarm 07:30 rings three seconds and times out.
    {al_hr_msb, al_hr_lsb, al_min_msb, al_min_lsb} = 16'h0730; al_set = 1'b1; al_en = 1'b1;
    step(); al_set = 1'b0;
    chk("al_set_ok_err", a_err, 1'b0);
    set_ld(24'h072959); load = 1'b1; step(); load = 1'b0;
    chk("al_pre_time", ta, 24'h072959);
    chk("al_pre_ring", a_ring, 1'b0);
    step();
    chk("al_trig_time", ta, 24'h073000);
    chk("al_trig_ring", a_ring, 1'b1);
    step();
    chk("al_s01_ring", a_ring, 1'b1);
    step();
    chk("al_s02_time", ta, 24'h073002);
    chk("al_s02_ring", a_ring, 1'b1);
    step();
    chk("al_s03_time", ta, 24'h073003);
    chk("al_s03_ring", a_ring, 1'b0);

    // Acknowledge at 07:30:01.
    set_ld(24'h072959); load = 1'b1; step(); load = 1'b0;
    step();
    chk("ack_trig_ring", a_ring, 1'b1);
    step();
    chk("ack_s01_time", ta, 24'h073001);
    chk("ack_s01_ring", a_ring, 1'b1);
    al_ack = 1'b1; step(); al_ack = 1'b0;
    chk("ack_drop_ring", a_ring, 1'b0);

    // Reset mid-ring clears time and invalidates the alarm.
    set_ld(24'h072959); load = 1'b1; step(); load = 1'b0;
    step(); step();
    chk("rr_s01_ring", a_ring, 1'b1);
    reset = 1'b1; step(); reset = 1'b0;
    chk("rr_time", ta, 24'h000000);
    chk("rr_ring", a_ring, 1'b0);
    set_ld(24'h072959); load = 1'b1; step(); load = 1'b0;
    chk("rr_reload_time", ta, 24'h072959);
    step();
    chk("rr_no_ring_time", ta, 24'h073000);
    chk("rr_no_ring", a_ring, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
